// File: rtl/spart_fifo_if.sv
// spart_fifo_if: processor I/O bus control and handshake signals for spart_fifo.
interface spart_fifo_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo: processor-addressable UART with TX/RX FIFOs, programmable divisor and sticky
// error flags; 8-N-1 framing, even parity added when SPART_PARITY_EN is defined.
module spart_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    spart_fifo_if.slave      bus,
    inout  wire  [7:0]       databus,
    output logic             txd,
    input  logic             rxd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef SPART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SPART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    logic             rd, wr, stat_rd, perr;
    logic [7:0]       wdata, rdata, status;
    logic [15:0]      div16, div_wr;
    logic [DIV_W-1:0] div_q, div_d, div_eff;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_push, tx_pop, tx_empty, tx_idle, tx_end;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_pop, rx_full, rx_accept, rx_half, rx_end;

    tx_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_tick_q, tx_tick_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_tick_q, rx_tick_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic             rx_push_q, rx_push_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, ferr_set;
`ifdef SPART_PARITY_EN
    logic             tx_par_q, tx_par_d, perr_q, perr_d, perr_set;
`endif

    assign rd       = bus.iocs && bus.iorw;
    assign wr       = bus.iocs && !bus.iorw;
    assign stat_rd  = rd && bus.ioaddr == 2'b01;
    assign wdata    = databus;
    assign databus  = rd ? rdata : 8'hzz;
    assign tx_empty = tx_cnt_q == '0;
    assign tx_idle  = tx_empty && tx_state_q == TX_IDLE;
    assign rx_full  = rx_cnt_q == CW'(FIFO_DEPTH);
    assign bus.tbr  = tx_cnt_q != CW'(FIFO_DEPTH);
    assign bus.rda  = rx_cnt_q != '0;
`ifdef SPART_PARITY_EN
    assign perr     = perr_q;
`else
    assign perr     = 1'b0;
`endif

    // Register file: read mux, divisor write, FIFO pointer/count bookkeeping and sticky flags
    always_comb begin
        div16     = 16'(div_q);
        div_wr    = wr && bus.ioaddr == 2'b10 ? {div16[15:8], wdata} :
                    wr && bus.ioaddr == 2'b11 ? {wdata, div16[7:0]} : div16;
        div_d     = DIV_W'(div_wr);
        div_eff   = div_q < DIV_W'(16) ? DIV_W'(16) : div_q;
        status    = {2'b00, perr, ferr_q, ovr_q, tx_idle, bus.tbr, bus.rda};
        rdata     = bus.ioaddr == 2'b00 ? (bus.rda ? rx_mem_q[rx_rp_q] : 8'h00) :
                    bus.ioaddr == 2'b01 ? status :
                    bus.ioaddr == 2'b10 ? div16[7:0] : div16[15:8];
        tx_push   = wr && bus.ioaddr == 2'b00 && bus.tbr;
        tx_wp_d   = tx_wp_q + AW'(tx_push);
        tx_rp_d   = tx_rp_q + AW'(tx_pop);
        tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_pop    = rd && bus.ioaddr == 2'b00 && bus.rda;
        rx_accept = rx_push_q && (!rx_full || rx_pop);
        rx_wp_d   = rx_wp_q + AW'(rx_accept);
        rx_rp_d   = rx_rp_q + AW'(rx_pop);
        rx_cnt_d  = rx_cnt_q + CW'(rx_accept) - CW'(rx_pop);
        ovr_d     = (ovr_q && !stat_rd) || (rx_push_q && rx_full && !rx_pop);
        ferr_d    = (ferr_q && !stat_rd) || ferr_set;
`ifdef SPART_PARITY_EN
        perr_d    = (perr_q && !stat_rd) || perr_set;
`endif
    end

    // Transmitter: load a byte from the TX FIFO when idle or straight out of the stop bit
    always_comb begin
        tx_end     = tx_tick_q == tx_div_q - DIV_W'(1);
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_end ? '0 : tx_tick_q + DIV_W'(1);
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
`ifdef SPART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE:  tx_tick_d = '0;
            TX_START: if (tx_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
            end
            TX_DATA:  if (tx_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
`ifdef SPART_PARITY_EN
                if (tx_bit_q == 3'd7) tx_state_d = TX_PAR;
`else
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
`endif
            end
`ifdef SPART_PARITY_EN
            TX_PAR:   if (tx_end) tx_state_d = TX_STOP;
`endif
            TX_STOP:  if (tx_end) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        if (!tx_empty && (tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_end))) begin
            tx_state_d = TX_START;
            tx_tick_d  = '0;
            tx_div_d   = div_eff;
            tx_sh_d    = tx_mem_q[tx_rp_q];
            tx_pop     = 1'b1;
`ifdef SPART_PARITY_EN
            tx_par_d   = ^tx_mem_q[tx_rp_q];
`endif
        end
    end

    // Serial output decoded from the transmitter state; reset forces IDLE so txd idles high
    always_comb begin
        txd = tx_state_q != TX_START;
        if (tx_state_q == TX_DATA) txd = tx_sh_q[0];
`ifdef SPART_PARITY_EN
        if (tx_state_q == TX_PAR) txd = tx_par_q;
`endif
    end

    // Receiver: start-bit qualification at half a bit, then one mid-bit sample per bit period
    always_comb begin
        rx_half    = rx_tick_q == (rx_div_q >> 1) - DIV_W'(1);
        rx_end     = rx_tick_q == rx_div_q - DIV_W'(1);
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_end ? '0 : rx_tick_q + DIV_W'(1);
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push_d  = 1'b0;
        ferr_set   = 1'b0;
`ifdef SPART_PARITY_EN
        perr_set   = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (!rx_s2_q && rx_s3_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_eff;
                end
            end
            RX_START: if (rx_half) begin
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_tick_d  = '0;
                rx_bit_d   = 3'd0;
            end
            RX_DATA: if (rx_end) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
`ifdef SPART_PARITY_EN
                if (rx_bit_q == 3'd7) rx_state_d = RX_PAR;
`else
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
`endif
            end
`ifdef SPART_PARITY_EN
            RX_PAR: if (rx_end) begin
                perr_set   = rx_s2_q != ^rx_sh_q;
                rx_state_d = RX_STOP;
            end
`endif
            RX_STOP: if (rx_end) begin
                rx_push_d  = 1'b1;
                ferr_set   = !rx_s2_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because pointers and counts define validity
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wdata;
        if (rx_accept) rx_mem_q[rx_wp_q] <= rx_sh_q;
    end

    // State registers; asynchronous reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DIV_W'(DEFAULT_DIV);
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_div_q   <= DIV_W'(16);
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_div_q   <= DIV_W'(16);
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_push_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef SPART_PARITY_EN
            tx_par_q   <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_push_q  <= rx_push_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
`ifdef SPART_PARITY_EN
            tx_par_q   <= tx_par_d;
            perr_q     <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: directed register, TX framing, RX framing, overflow, error and reset checks.
module tb_spart_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       txd;
    wire  [7:0] databus;
    int         n_cmp = 0;
    int         n_err = 0;

    spart_fifo_if bus();
    assign databus = wen ? wdata : 8'hzz;

    spart_fifo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; wen = 1'b1; wdata = d;
        @(negedge clk);
        bus.iocs = 1'b0; wen = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        bus.iocs = 1'b0;
        chk(tag, d, exp);
    endtask

    // Called half a bit into the start bit; returns half a bit into the stop bit.
    task automatic tx_expect(input logic [7:0] b, input string tag);
        chk1($sformatf("%s_start", tag), txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(16);
            chk1($sformatf("%s_bit%0d", tag, i), txd, b[i]);
        end
`ifdef SPART_PARITY_EN
        cyc(16);
        chk1($sformatf("%s_par", tag), txd, ^b);
`endif
        cyc(16);
        chk1($sformatf("%s_stop", tag), txd, 1'b1);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(16);
        end
`ifdef SPART_PARITY_EN
        rxd = ^b;
        cyc(16);
`endif
        rxd = stop;
        cyc(16);
        rxd = 1'b1;
    endtask

    initial begin
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        chk1("reset_txd", txd, 1'b1);
        chk1("reset_rda", bus.rda, 1'b0);
        chk1("reset_tbr", bus.tbr, 1'b1);
        rd_chk(2'b01, 8'h06, "reset_status");
        rd_chk(2'b10, 8'hB2, "reset_div_lo");
        rd_chk(2'b11, 8'h01, "reset_div_hi");
        rd_chk(2'b00, 8'h00, "reset_rx_empty");

        wr(2'b10, 8'h10);
        wr(2'b11, 8'h00);
        rd_chk(2'b10, 8'h10, "div_lo");
        rd_chk(2'b11, 8'h00, "div_hi");

        wr(2'b00, 8'hA5);
        chk1("a5_pre", txd, 1'b1);
        cyc(1);
        chk1("a5_low_next", txd, 1'b0);
        cyc(7);
        tx_expect(8'hA5, "a5");
        cyc(9);
        rd_chk(2'b01, 8'h06, "a5_tx_idle");

        for (int i = 0; i < 10; i++) wr(2'b00, 8'h30 + 8'(i));
        chk1("b2b_tbr_full", bus.tbr, 1'b0);
        tx_expect(8'h30, "b2b0");
        for (int k = 1; k < 9; k++) begin
            cyc(16);
            tx_expect(8'h30 + 8'(k), $sformatf("b2b%0d", k));
        end
        chk1("b2b_tbr_back", bus.tbr, 1'b1);
        cyc(16);
        chk1("b2b_no_extra", txd, 1'b1);
        cyc(8);
        rd_chk(2'b01, 8'h06, "b2b_drained");

        rx_send(8'h3C, 1'b1);
        cyc(2);
        chk1("rx_rda_set", bus.rda, 1'b1);
        rd_chk(2'b00, 8'h3C, "rx_data");
        chk1("rx_rda_clr", bus.rda, 1'b0);
        rd_chk(2'b00, 8'h00, "rx_empty_read");

        for (int i = 0; i < 9; i++) rx_send(8'h50 + 8'(i), 1'b1);
        cyc(2);
        rd_chk(2'b01, 8'h0F, "ovr_status");
        rd_chk(2'b01, 8'h07, "ovr_cleared");
        for (int i = 0; i < 8; i++) rd_chk(2'b00, 8'h50 + 8'(i), $sformatf("ovr_byte%0d", i));
        chk1("ovr_rda_clr", bus.rda, 1'b0);
        rd_chk(2'b00, 8'h00, "ovr_empty");

        rx_send(8'h5A, 1'b0);
        cyc(2);
        rd_chk(2'b01, 8'h17, "ferr_status");
        rd_chk(2'b00, 8'h5A, "ferr_data");
        rd_chk(2'b01, 8'h06, "ferr_cleared");

        rxd = 1'b0;
        cyc(1);
        rxd = 1'b1;
        cyc(40);
        chk1("glitch_rda", bus.rda, 1'b0);
        rd_chk(2'b01, 8'h06, "glitch_status");

        wr(2'b00, 8'h00);
        wr(2'b00, 8'hFF);
        cyc(40);
        chk1("rst_mid_txd_low", txd, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rst_async_txd", txd, 1'b1);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk1("rst_rda", bus.rda, 1'b0);
        chk1("rst_tbr", bus.tbr, 1'b1);
        rd_chk(2'b01, 8'h06, "rst_status");
        rd_chk(2'b10, 8'hB2, "rst_div_lo");
        cyc(20);
        chk1("rst_txd_idle", txd, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
